pwm_controller: RTL and testbench

Sequencing controller for the PWM datapath. It runs a prescaled period counter and drives the existing comparator_less, with the counter on operand1 and the active duty on operand2. It double-buffers duty updates through a valid/ready handshake so a new duty only takes effect at a period boundary. It also manages start/graceful-stop sequencing. It sits between the register/config interface and the PWM output pin.

---
 rtl/pwm_pkg.sv | 15 +
 rtl/comparator_less.sv | 12 +
 rtl/pwm_controller.sv | 123 ++++++++++++
 tb/tb_pwm_controller.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared types and helpers for the PWM sequencing controller.
package pwm_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } state_t;

    // Largest meaningful duty for a counter of the given width: always high.
    function automatic int full_duty(input int bits);
        return 1 << bits;
    endfunction

endpackage

// File: rtl/comparator_less.sv
// Unsigned less-than between the period counter and a duty value one bit wider.
module comparator_less #(
    parameter int BITS = 4
) (
    input  logic [BITS-1:0] operand1,
    input  logic [BITS:0]   operand2,
    output logic            less
);

    assign less = ({1'b0, operand1} < operand2);

endmodule

// File: rtl/pwm_controller.sv
// Prescaled PWM period counter with double-buffered duty and graceful stop.
//   state    | meaning
//   IDLE     | counter held at 0, output low, waiting for en
//   RUN      | counting, driving pwm_out
//   STOPPING | en dropped; finishing the current period, then IDLE
module pwm_controller
    import pwm_pkg::*;
#(
    parameter int BITS = 4,
    parameter int PS_W = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [PS_W-1:0] prescale,
    input  logic [BITS:0]   duty_in,
    input  logic            duty_valid,
    output logic            duty_ready,
    output logic            pwm_out,
    output logic            period_end,
    output logic            busy
);

    localparam logic [BITS:0]   FULL    = (BITS+1)'(full_duty(BITS));
    localparam logic [BITS-1:0] CNT_MAX = '1;

    state_t          state_q, state_d;
    logic [PS_W-1:0] ps_cnt_q, ps_cnt_d;
    logic [BITS-1:0] cnt_q, cnt_d;
    logic [BITS:0]   duty_shadow_q, duty_shadow_d;
    logic [BITS:0]   duty_active_q, duty_active_d;
    logic            pending_q, pending_d;
    logic            pwm_q, pwm_d;
    logic            period_end_q, period_end_d;

    logic tick;
    logic wrap;
    logic less;

    comparator_less #(.BITS(BITS)) u_cmp (
        .operand1 (cnt_q),
        .operand2 (duty_active_q),
        .less     (less)
    );

    // >= rather than == so lowering prescale mid-count ticks at once instead of rolling over.
    assign tick = (state_q != IDLE) && (ps_cnt_q >= prescale);
    assign wrap = tick && (cnt_q == CNT_MAX);

    always_comb begin
        state_d       = state_q;
        ps_cnt_d      = ps_cnt_q;
        cnt_d         = cnt_q;
        duty_shadow_d = duty_shadow_q;
        duty_active_d = duty_active_q;
        pending_d     = pending_q;
        period_end_d  = wrap;
        pwm_d         = less && (state_q != IDLE);

        if (state_q == IDLE) begin
            ps_cnt_d = '0;
            cnt_d    = '0;
            if (en) begin
                duty_active_d = duty_shadow_q;
                pending_d     = 1'b0;
                state_d       = RUN;
            end
        end else begin
            if (tick) begin
                ps_cnt_d = '0;
                cnt_d    = cnt_q + 1'b1;
            end else begin
                ps_cnt_d = ps_cnt_q + 1'b1;
            end
            if (wrap && pending_q) begin
                duty_active_d = duty_shadow_q;
                pending_d     = 1'b0;
            end
            case (state_q)
                RUN:      if (!en) state_d = STOPPING;
                STOPPING: begin
                    if (en)        state_d = RUN;
                    else if (wrap) state_d = IDLE;
                end
                default:  state_d = state_q;
            endcase
        end

        // A capture landing on the start edge stays pending for the next boundary.
        if (duty_valid && !pending_q) begin
            duty_shadow_d = (duty_in > FULL) ? FULL : duty_in;
            pending_d     = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            ps_cnt_q      <= '0;
            cnt_q         <= '0;
            duty_shadow_q <= '0;
            duty_active_q <= '0;
            pending_q     <= 1'b0;
            pwm_q         <= 1'b0;
            period_end_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            ps_cnt_q      <= ps_cnt_d;
            cnt_q         <= cnt_d;
            duty_shadow_q <= duty_shadow_d;
            duty_active_q <= duty_active_d;
            pending_q     <= pending_d;
            pwm_q         <= pwm_d;
            period_end_q  <= period_end_d;
        end
    end

    assign duty_ready = !pending_q;
    assign pwm_out    = pwm_q;
    assign period_end = period_end_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_pwm_controller.sv
// Directed bench for pwm_controller: per-clk expected pwm/period_end bits queued per period, popped as the DUT runs.
module tb_pwm_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [3:0] prescale;
    logic [4:0] duty_in;
    logic       duty_valid;
    logic       duty_ready;
    logic       pwm_out;
    logic       period_end;
    logic       busy;

    typedef struct {
        logic pwm;
        logic pe;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    pwm_controller #(.BITS(4), .PS_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .prescale   (prescale),
        .duty_in    (duty_in),
        .duty_valid (duty_valid),
        .duty_ready (duty_ready),
        .pwm_out    (pwm_out),
        .period_end (period_end),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One period: sample j sees cnt = j/(ps+1); wrap pulse lands on the last sample.
    task automatic push_period(input int duty, input int ps);
        int len;
        len = 16 * (ps + 1);
        for (int j = 0; j < len; j++) begin
            exp_t e;
            e.pwm = (j < duty * (ps + 1));
            e.pe  = (j == len - 1);
            sb.push_back(e);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL sb_underflow observed=empty expected=entry");
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("pwm", 32'(pwm_out), 32'(e.pwm));
                chk("period_end", 32'(period_end), 32'(e.pe));
            end
        end
    endtask

    // One period at old duty while offering new duty on its first edge.
    task automatic apply(input int old_d, input int new_d);
        push_period(old_d, 0);
        duty_in    = 5'(new_d);
        duty_valid = 1'b1;
        run(1);
        duty_valid = 1'b0;
        run(15);
    endtask

    initial begin
        rst_n      = 1'b0;
        en         = 1'b0;
        prescale   = 4'd0;
        duty_in    = 5'd0;
        duty_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pwm", 32'(pwm_out), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ready", 32'(duty_ready), 1);
        chk("rst_pe", 32'(period_end), 0);
        rst_n = 1'b1;

        // idle: nothing moves
        for (int i = 0; i < 50; i++) begin
            step();
            chk("idle_pe", 32'(period_end), 0);
            chk("idle_pwm", 32'(pwm_out), 0);
        end
        chk("idle_busy", 32'(busy), 0);

        // load duty 4 while idle, then start
        duty_in    = 5'd4;
        duty_valid = 1'b1;
        step();
        duty_valid = 1'b0;
        chk("idle_capture_ready", 32'(duty_ready), 0);
        en = 1'b1;
        step();
        chk("start_busy", 32'(busy), 1);
        chk("start_ready", 32'(duty_ready), 1);
        chk("start_pwm", 32'(pwm_out), 0);
        repeat (3) push_period(4, 0);
        run(48);
        chk("run_busy", 32'(busy), 1);

        // duty edges: 16 full, 0 empty, 20 clamps to 16
        apply(4, 16);
        repeat (2) push_period(16, 0);
        run(32);
        apply(16, 0);
        repeat (2) push_period(0, 0);
        run(32);
        apply(0, 20);
        repeat (2) push_period(16, 0);
        run(32);
        apply(16, 8);

        // mid-period update: current period keeps 8, next gets 12, second offer dropped
        push_period(8, 0);
        run(5);
        duty_in    = 5'd12;
        duty_valid = 1'b1;
        run(1);
        duty_valid = 1'b0;
        chk("pending_ready", 32'(duty_ready), 0);
        duty_in    = 5'd2;
        duty_valid = 1'b1;
        run(1);
        duty_valid = 1'b0;
        chk("second_offer_ready", 32'(duty_ready), 0);
        run(8);
        chk("pre_wrap_ready", 32'(duty_ready), 0);
        run(1);
        chk("post_wrap_ready", 32'(duty_ready), 1);
        repeat (2) push_period(12, 0);
        run(32);
        chk("after_update_ready", 32'(duty_ready), 1);

        // prescale 2, duty 8
        apply(12, 8);
        prescale = 4'd2;
        push_period(8, 2);
        run(48);

        // prescale 5, lowered to 1 while cnt=15 and ps_cnt=4: wrap on the very next clk
        prescale = 4'd5;
        for (int j = 0; j < 95; j++) begin
            exp_t e;
            e.pwm = ((j / 6) < 8);
            e.pe  = (j == 94);
            sb.push_back(e);
        end
        run(94);
        prescale = 4'd1;
        run(1);
        prescale = 4'd0;

        // drop and re-raise en within a period: waveform unbroken
        push_period(8, 0);
        run(3);
        en = 1'b0;
        run(2);
        chk("stopping_busy", 32'(busy), 1);
        en = 1'b1;
        run(11);
        chk("resume_busy", 32'(busy), 1);

        // graceful stop at cnt=6: finishes the period then idles
        push_period(8, 0);
        run(6);
        en = 1'b0;
        run(1);
        chk("stop_busy_mid", 32'(busy), 1);
        run(9);
        chk("stop_busy_end", 32'(busy), 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stopped_pwm", 32'(pwm_out), 0);
            chk("stopped_pe", 32'(period_end), 0);
        end

        // restart at full duty, then reset mid-run with an update pending
        duty_in    = 5'd16;
        duty_valid = 1'b1;
        step();
        duty_valid = 1'b0;
        en = 1'b1;
        step();
        chk("restart_busy", 32'(busy), 1);
        push_period(16, 0);
        run(16);
        push_period(16, 0);
        duty_in    = 5'd4;
        duty_valid = 1'b1;
        run(1);
        duty_valid = 1'b0;
        chk("pre_reset_ready", 32'(duty_ready), 0);
        run(3);
        chk("pre_reset_pwm", 32'(pwm_out), 1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_pwm", 32'(pwm_out), 0);
        chk("async_rst_busy", 32'(busy), 0);
        chk("async_rst_pe", 32'(period_end), 0);
        chk("async_rst_ready", 32'(duty_ready), 1);
        sb.delete();
        en = 1'b0;
        #2;
        rst_n = 1'b1;

        // restart with no new offer: shadow was cleared, so duty 0
        en = 1'b1;
        step();
        chk("post_rst_busy", 32'(busy), 1);
        chk("post_rst_ready", 32'(duty_ready), 1);
        push_period(0, 0);
        run(16);
        chk("sb_drained", 32'(sb.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
